// File: rtl/pow_5_arg_scheduler_pkg.sv
// Shared constants and types for the x^5 argument scheduler.
package pow_5_arg_scheduler_pkg;

    // Constants shared with the x^5 unit.
    localparam int POW5_W       = 8;
    localparam int POW5_LATENCY = 6;   // enabled cycles from arg_vld to res_vld
    localparam int POW5_MIN_GAP = 5;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } sched_state_e;

    function automatic bit is_pow2(input int v);
        return (v > 0) && ((v & (v - 1)) == 0);
    endfunction

endpackage

// File: rtl/pow_5_arg_scheduler_if.sv
// Upstream stream, enable and x^5-unit-facing signals of the scheduler.
interface pow_5_arg_scheduler_if
    import pow_5_arg_scheduler_pkg::*;
#(
    parameter int W     = POW5_W,
    parameter int DEPTH = 4
);
    logic                   clk_en;
    logic                   in_vld;
    logic                   in_rdy;
    logic [W-1:0]           in_data;
    logic                   arg_vld;
    logic [W-1:0]           n;
    logic [$clog2(DEPTH):0] level;

    modport slave  (input  clk_en, in_vld, in_data,
                    output in_rdy, arg_vld, n, level);
    modport master (output clk_en, in_vld, in_data,
                    input  in_rdy, arg_vld, n, level);
endinterface

// File: rtl/pow_5_arg_fifo.sv
// Small synchronous FIFO with registered occupancy; memory is not reset.
module pow_5_arg_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   en_i,
    input  logic                   push_i,
    input  logic                   pop_i,
    input  logic [W-1:0]           wdata_i,
    output logic [W-1:0]           rdata_o,
    output logic [$clog2(DEPTH):0] level_o,
    output logic                   full_o,
    output logic                   empty_o
);
    localparam int PW = $clog2(DEPTH);
    localparam int LW = PW + 1;

    logic [W-1:0]  mem_q [DEPTH];
    logic [PW-1:0] wr_ptr_q, rd_ptr_q;
    logic [LW-1:0] level_q, level_d;
    logic          push_w, pop_w;

    assign full_o  = (level_q == LW'(DEPTH));
    assign empty_o = (level_q == '0);
    assign push_w  = en_i && push_i && !full_o;
    assign pop_w   = en_i && pop_i && !empty_o;
    assign rdata_o = mem_q[rd_ptr_q];
    assign level_o = level_q;

    // Next occupancy; simultaneous push and pop leaves it unchanged.
    always_comb begin
        level_d = level_q;
        case ({push_w, pop_w})
            2'b10:   level_d = level_q + LW'(1);
            2'b01:   level_d = level_q - LW'(1);
            default: level_d = level_q;
        endcase
    end

    // Storage write, no reset needed since reads are gated by level.
    always_ff @(posedge clk) begin
        if (push_w) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end

    // Pointers and occupancy; pointers wrap naturally at DEPTH.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            if (push_w) wr_ptr_q <= wr_ptr_q + PW'(1);
            if (pop_w)  rd_ptr_q <= rd_ptr_q + PW'(1);
            level_q <= level_d;
        end
    end
endmodule

// File: rtl/pow_5_arg_scheduler.sv
// Buffers x^5 arguments and issues them as single-cycle arg_vld pulses spaced
// GAP enabled cycles apart, holding n stable between issues.
//
// state   | meaning
// ST_IDLE | nothing in flight; issue as soon as the FIFO holds a word
// ST_WAIT | gap running; gap_cnt counts down to 0, then issue or go idle
module pow_5_arg_scheduler
    import pow_5_arg_scheduler_pkg::*;
#(
    parameter int W     = POW5_W,
    parameter int DEPTH = 4,
    parameter int GAP   = 6
) (
    input  logic                  clk,
    input  logic                  rst,
    pow_5_arg_scheduler_if.slave  bus
);
    localparam int GCW = $clog2(GAP);

    if (GAP < POW5_MIN_GAP) begin : g_bad_gap
        $error("pow_5_arg_scheduler: GAP below the x^5 unit minimum");
    end
    if (!is_pow2(DEPTH) || DEPTH < 2) begin : g_bad_depth
        $error("pow_5_arg_scheduler: DEPTH must be a power of two >= 2");
    end

    sched_state_e         state_q;
    logic [GCW-1:0]       gap_cnt_q;
    logic                 arg_vld_q;
    logic [W-1:0]         n_q;

    logic [W-1:0]         head_w;
    logic [$clog2(DEPTH):0] level_w;
    logic                 full_w, empty_w;
    logic                 in_rdy_w, issue_w;

    // in_rdy comes from registered full, so no push ever lands on a full FIFO.
    assign in_rdy_w = !full_w && !rst;

    // The counter is loaded with GAP-1 and the decision is taken on the edge
    // where it already reads 0, giving exactly GAP enabled cycles between issues.
    assign issue_w = !empty_w && ((state_q == ST_IDLE) || (gap_cnt_q == '0));

    pow_5_arg_fifo #(.W(W), .DEPTH(DEPTH)) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .en_i    (bus.clk_en),
        .push_i  (bus.in_vld && in_rdy_w),
        .pop_i   (issue_w),
        .wdata_i (bus.in_data),
        .rdata_o (head_w),
        .level_o (level_w),
        .full_o  (full_w),
        .empty_o (empty_w)
    );

    // Issue FSM with gap timer and registered arg_vld/n; n changes only on issue.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            gap_cnt_q <= '0;
            arg_vld_q <= 1'b0;
            n_q       <= '0;
        end else if (bus.clk_en) begin
            arg_vld_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (issue_w) begin
                        n_q       <= head_w;
                        arg_vld_q <= 1'b1;
                        gap_cnt_q <= GCW'(GAP - 1);
                        state_q   <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (gap_cnt_q != '0) begin
                        gap_cnt_q <= gap_cnt_q - GCW'(1);
                    end else if (issue_w) begin
                        n_q       <= head_w;
                        arg_vld_q <= 1'b1;
                        gap_cnt_q <= GCW'(GAP - 1);
                    end else begin
                        state_q <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign bus.in_rdy  = in_rdy_w;
    assign bus.arg_vld = arg_vld_q;
    assign bus.n       = n_q;
    assign bus.level   = level_w;
endmodule
